canny_frame_writer: RTL and testbench

// - Drains the 8-bit edge-image output FIFO of the Canny pipeline (FIFO reader side).
// - Packs 4 pixels into one 32-bit word and writes the words to DDR3 over an Avalon-MM master.
// - One frame (WIDTH*HEIGHT pixels) is written per start request, at consecutive word addresses.
// - Sits between canny_top's img_out FIFO and the HPS/DDR3 bridge.

---
 rtl/canny_pkg.sv | 25 ++
 rtl/canny_frame_writer.sv | 146 ++++++++++++++
 tb/tb_canny_frame_writer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny frame writer.
// Contents:
//   wr_state_t      - frame writer FSM states
//   BYTES_PER_WORD  - pixels (bytes) packed into one Avalon word
//   lane_mask()     - byteenable for a word whose last filled lane is given
package canny_pkg;

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} wr_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Lanes 0..last_lane hold pixels; everything above is empty.
  function automatic logic [3:0] lane_mask(input logic [1:0] last_lane);
    logic [3:0] m;
    m = 4'b1111;
    case (last_lane)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/canny_frame_writer.sv
// Canny frame writer: drains the 8-bit edge-image FIFO (show-ahead reader
// side), packs 4 pixels little-endian into a 32-bit word and writes the words
// to consecutive DDR3 word addresses through an Avalon-MM write master.
// One frame of WIDTH*HEIGHT pixels is written per accepted start.
//
// Ports:
//   clock, reset     single clock, synchronous active-high reset
//   start, base_addr frame request (only honoured in IDLE); byte address of pixel 0
//   in_rd_en         FIFO pop
//   in_empty         FIFO empty
//   in_dout          FIFO head pixel, valid whenever in_empty==0
//   avm_*            Avalon-MM write master (address, write, writedata,
//                    byteenable, waitrequest)
//   busy             high from accepted start until the DONE cycle
//   done             one-cycle pulse after the last word is accepted
//   dbg_state        current FSM state, for observation only
//
// Handshakes: a FIFO pop happens on every cycle with in_rd_en=1 (in_rd_en is
// only raised while in_empty=0). An Avalon write transfers on a cycle with
// avm_write=1 and avm_waitrequest=0; until then address, data and byteenable
// stay frozen because they come straight from registers.
module canny_frame_writer
  import canny_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              in_rd_en,
  input  logic              in_empty,
  input  logic [7:0]        in_dout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output wr_state_t         dbg_state
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(N + 1);

  wr_state_t         r_state;
  wr_state_t         w_next_state;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_lane;
  logic [31:0]       r_buf;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;

  logic        w_last_pixel;
  logic        w_frame_end;
  logic [31:0] w_word;

  // The pop about to happen brings the count to N.
  assign w_last_pixel = (r_count == CNT_W'(N - 1));
  assign w_frame_end  = (r_count == CNT_W'(N));
  // Lanes above r_lane are still zero, so OR-ing the pixel in is enough and
  // leaves unused bytes of a partial final word at 0.
  assign w_word       = r_buf | ({24'd0, in_dout} << {r_lane, 3'b000});

  always_comb begin
    w_next_state = r_state;
    in_rd_en     = 1'b0;
    avm_write    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = PACK;
      end
      PACK: begin
        busy     = 1'b1;
        in_rd_en = !in_empty;
        if (!in_empty && (r_lane == 2'd3 || w_last_pixel)) w_next_state = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        avm_write = 1'b1;
        if (!avm_waitrequest) w_next_state = w_frame_end ? DONE : PACK;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_lane  <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr  <= base_addr;
            r_count <= '0;
            r_lane  <= '0;
            r_buf   <= '0;
          end
        end
        PACK: begin
          if (in_rd_en) begin
            r_buf   <= w_word;
            r_lane  <= r_lane + 2'd1;
            r_count <= r_count + 1'b1;
            // Snapshot the finished word so the bus sees it the next cycle.
            if (r_lane == 2'd3 || w_last_pixel) begin
              r_wdata <= w_word;
              r_be    <= lane_mask(r_lane);
            end
          end
        end
        WRITE: begin
          if (!avm_waitrequest) begin
            r_addr <= r_addr + ADDR_W'(BYTES_PER_WORD);
            r_lane <= '0;
            r_buf  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = r_be;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_canny_frame_writer.sv
// Bench for canny_frame_writer: a 4x2 frame instance driven by a FIFO and
// Avalon slave model with a behavioural scoreboard, plus a 3x1 instance for
// the partial final word.
module tb_canny_frame_writer;
  import canny_pkg::*;

  localparam int N_A = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic        in_rd_en;
  logic        in_empty;
  logic [7:0]  in_dout;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  wr_state_t   dbg_state;

  canny_frame_writer #(.WIDTH(4), .HEIGHT(2), .ADDR_W(32)) dut (
    .clock(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Second instance: 3x1 frame, partial word.
  logic        start_b;
  logic [31:0] base_b;
  logic        in_rd_en_b;
  logic        in_empty_b;
  logic [7:0]  in_dout_b;
  logic [31:0] addr_b;
  logic        write_b;
  logic [31:0] wdata_b;
  logic [3:0]  be_b;
  logic        wait_b;
  logic        busy_b;
  logic        done_b;
  wr_state_t   dbg_b;
  logic [7:0]  pix_b [0:3] = '{8'hAA, 8'hBB, 8'hCC, 8'h00};
  int          idx_b = 0;

  canny_frame_writer #(.WIDTH(3), .HEIGHT(1), .ADDR_W(32)) dut_b (
    .clock(clk), .reset(reset), .start(start_b), .base_addr(base_b),
    .in_rd_en(in_rd_en_b), .in_empty(in_empty_b), .in_dout(in_dout_b),
    .avm_address(addr_b), .avm_write(write_b),
    .avm_writedata(wdata_b), .avm_byteenable(be_b),
    .avm_waitrequest(wait_b), .busy(busy_b), .done(done_b),
    .dbg_state(dbg_b)
  );

  assign in_empty_b = (idx_b >= 3);
  assign in_dout_b  = pix_b[idx_b[1:0]];
  always @(posedge clk) if (in_rd_en_b && !in_empty_b) idx_b <= idx_b + 1;

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired or unexpected event", name);
  endtask

  // ---------------- FIFO + Avalon slave model ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] feed_q[$];
  int         feed_pct   = 100;
  int         stall_left = 0;
  bit         rand_wait  = 0;
  int         pop_total  = 0;
  bit         do_pop;

  task automatic refresh();
    in_empty = (fifo_q.size() == 0);
    in_dout  = in_empty ? 8'h00 : fifo_q[0];
  endtask

  initial begin
    in_empty        = 1'b1;
    in_dout         = 8'h00;
    avm_waitrequest = 1'b0;
  end

  always begin
    @(negedge clk);
    do_pop = in_rd_en && !in_empty;
    @(posedge clk);
    #1;
    if (do_pop && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_total++;
    end
    if (feed_q.size() > 0 && $urandom_range(0, 99) < feed_pct)
      fifo_q.push_back(feed_q.pop_front());
    refresh();
    if (stall_left > 0 && avm_write) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else begin
      avm_waitrequest = rand_wait && ($urandom_range(0, 2) == 0);
    end
  end

  // ---------------- scoreboard / behavioural model ----------------
  // exp_q holds {address, data, byteenable} of every word still owed.
  logic [67:0] exp_q[$];
  logic [67:0] acc_log[$];
  bit  frame_active  = 0;
  bit  write_pending = 0;
  bit  expect_done   = 0;
  int  pops_in_frame = 0;
  int  done_obs      = 0;
  int  stall_obs     = 0;

  always @(negedge clk) begin
    bit idle_now;
    if (reset) begin
      frame_active  = 0;
      write_pending = 0;
      expect_done   = 0;
      pops_in_frame = 0;
      exp_q.delete();
    end else begin
      idle_now = !frame_active && !expect_done;
      check("busy", 68'(busy), 68'(frame_active));
      check("done", 68'(done), 68'(expect_done));
      check("avm_write", 68'(avm_write), 68'(write_pending));
      check("in_rd_en", 68'(in_rd_en), 68'(frame_active && !write_pending && !in_empty));
      if (write_pending && avm_write) begin
        if (exp_q.size() == 0) fail_now("unexpected_write");
        else check("write_word", {avm_address, avm_writedata, avm_byteenable}, exp_q[0]);
      end
      if (done) done_obs++;
      if (avm_write && avm_waitrequest) stall_obs++;
      // advance the model to the next cycle
      if (expect_done) expect_done = 0;
      if (frame_active && write_pending) begin
        if (!avm_waitrequest) begin
          acc_log.push_back({avm_address, avm_writedata, avm_byteenable});
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          write_pending = 0;
          if (pops_in_frame == N_A) begin
            frame_active = 0;
            expect_done  = 1;
          end
        end
      end else if (frame_active && !in_empty) begin
        pops_in_frame++;
        if (pops_in_frame % 4 == 0 || pops_in_frame == N_A) write_pending = 1;
      end
      if (start && idle_now) begin
        frame_active  = 1;
        pops_in_frame = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] frame_px[$];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic build_exp(input logic [31:0] base);
    for (int k = 0; k < (N_A + 3) / 4; k++) begin
      logic [31:0] d;
      logic [3:0]  be;
      d  = '0;
      be = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < N_A) begin
          d[8*j +: 8] = frame_px[4*k+j];
          be[j]       = 1'b1;
        end
      end
      exp_q.push_back({base + 32'(4 * k), d, be});
    end
  endtask

  // Preload the first npre pixels into the FIFO; optionally trickle the rest.
  task automatic launch(input logic [31:0] base, input int npre, input bit feed_rest);
    build_exp(base);
    for (int i = 0; i < frame_px.size(); i++) begin
      if (i < npre) fifo_q.push_back(frame_px[i]);
      else if (feed_rest) feed_q.push_back(frame_px[i]);
    end
    refresh();
    start     = 1'b1;
    base_addr = base;
    cyc(1);
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((frame_active || expect_done) && n < budget) begin
      cyc(1);
      n++;
    end
    if (frame_active || expect_done) fail_now(name);
    check({name, "_drained"}, 68'(exp_q.size()), 68'(0));
  endtask

  task automatic seq_px(input logic [7:0] first);
    frame_px.delete();
    for (int i = 0; i < N_A; i++) frame_px.push_back(first + 8'(i));
  endtask

  task automatic prep();
    acc_log.delete();
    pop_total = 0;
    done_obs  = 0;
    stall_obs = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    start_b   = 1'b0;
    base_b    = '0;
    wait_b    = 1'b0;
    cyc(3);
    reset = 1'b0;

    // reset values
    @(negedge clk);
    check("rst_write", 68'(avm_write), 68'(0));
    check("rst_addr", 68'(avm_address), 68'(0));
    check("rst_data", 68'(avm_writedata), 68'(0));
    check("rst_be", 68'(avm_byteenable), 68'(0));
    check("rst_busy", 68'(busy), 68'(0));
    check("rst_done", 68'(done), 68'(0));
    check("rst_rd_en", 68'(in_rd_en), 68'(0));
    cyc(1);

    // basic frame, no stalls
    seq_px(8'h01);
    prep();
    launch(32'h1000, 8, 0);
    wait_idle(200, "t1");
    check("t1_nwrites", 68'(acc_log.size()), 68'(2));
    check("t1_w0", acc_log[0], {32'h1000, 32'h04030201, 4'hF});
    check("t1_w1", acc_log[1], {32'h1004, 32'h08070605, 4'hF});
    check("t1_pops", 68'(pop_total), 68'(8));
    check("t1_done_pulses", 68'(done_obs), 68'(1));
    cyc(2);

    // waitrequest held 3 cycles on the first write
    prep();
    stall_left = 3;
    launch(32'h1000, 8, 0);
    wait_idle(200, "t2");
    check("t2_nwrites", 68'(acc_log.size()), 68'(2));
    check("t2_stalls", 68'(stall_obs), 68'(3));
    check("t2_w0", acc_log[0], {32'h1000, 32'h04030201, 4'hF});
    check("t2_pops", 68'(pop_total), 68'(8));
    cyc(2);

    // FIFO empty for 10 cycles between pixels 2 and 3
    prep();
    launch(32'h1000, 2, 0);
    n = 0;
    while (pop_total < 2 && n < 50) begin cyc(1); n++; end
    if (pop_total < 2) fail_now("t3_first_pops");
    cyc(10);
    check("t3_gap_pops", 68'(pop_total), 68'(2));
    for (int i = 2; i < N_A; i++) fifo_q.push_back(frame_px[i]);
    refresh();
    wait_idle(200, "t3");
    check("t3_w0", acc_log[0], {32'h1000, 32'h04030201, 4'hF});
    check("t3_w1", acc_log[1], {32'h1004, 32'h08070605, 4'hF});
    cyc(2);

    // start while busy is ignored
    prep();
    launch(32'h1000, 8, 0);
    cyc(3);
    start     = 1'b1;
    base_addr = 32'h2000;
    cyc(1);
    start     = 1'b0;
    wait_idle(200, "t4");
    check("t4_nwrites", 68'(acc_log.size()), 68'(2));
    check("t4_w0", acc_log[0], {32'h1000, 32'h04030201, 4'hF});
    check("t4_w1", acc_log[1], {32'h1004, 32'h08070605, 4'hF});
    cyc(2);

    // reset after the first accepted write, then a fresh frame at 0x3000
    prep();
    launch(32'h1000, 4, 0);
    n = 0;
    while (acc_log.size() < 1 && n < 100) begin cyc(1); n++; end
    if (acc_log.size() < 1) fail_now("t5_first_write");
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    check("t5_write_after_rst", 68'(avm_write), 68'(0));
    check("t5_busy_after_rst", 68'(busy), 68'(0));
    check("t5_rd_en_after_rst", 68'(in_rd_en), 68'(0));
    cyc(1);
    seq_px(8'h11);
    prep();
    launch(32'h3000, 8, 0);
    wait_idle(200, "t5");
    check("t5_w0", acc_log[0], {32'h3000, 32'h14131211, 4'hF});
    check("t5_w1", acc_log[1], {32'h3004, 32'h18171615, 4'hF});
    cyc(2);

    // random frames: random pixels, FIFO fill rate and waitrequest
    rand_wait = 1;
    for (int f = 0; f < 8; f++) begin
      logic [31:0] base;
      frame_px.delete();
      for (int i = 0; i < N_A; i++) frame_px.push_back(8'($urandom_range(0, 255)));
      base     = (f == 7) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      feed_pct = $urandom_range(30, 100);
      prep();
      launch(base, 0, 1);
      wait_idle(2000, "rand");
      check("rand_nwrites", 68'(acc_log.size()), 68'(2));
      cyc($urandom_range(1, 4));
    end
    check("wrap_addr", 68'(acc_log[1][67:36]), 68'(0));
    rand_wait = 0;
    feed_pct  = 100;
    cyc(2);

    // 3x1 frame: single partial word
    base_b  = 32'h5000;
    start_b = 1'b1;
    cyc(1);
    start_b = 1'b0;
    n = 0;
    @(negedge clk);
    while (!write_b && n < 50) begin @(negedge clk); n++; end
    if (!write_b) fail_now("p_write_timeout");
    check("p_addr", 68'(addr_b), 68'(32'h5000));
    check("p_data", 68'(wdata_b), 68'(32'h00CCBBAA));
    check("p_be", 68'(be_b), 68'(4'b0111));
    check("p_pops", 68'(idx_b), 68'(3));
    @(negedge clk);
    check("p_done", 68'(done_b), 68'(1));
    check("p_busy_at_done", 68'(busy_b), 68'(0));
    check("p_write_at_done", 68'(write_b), 68'(0));
    @(negedge clk);
    check("p_done_once", 68'(done_b), 68'(0));
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
